// File: rtl/dot4x_mmcm_reconfig.sv
// Runtime DRP reconfiguration controller for the dot4x MMCM: holds the MMCM in reset,
// read-modify-writes its DRP registers from DRP_TABLE, then releases it and waits for lock.
// Optional readback check after every write: define DOT4X_RECONFIG_VERIFY_EN.
module dot4x_mmcm_reconfig #(
  parameter int NUM_MODES = 2,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_MODES*NUM_REGS*39-1:0] DRP_TABLE = '0,
  parameter int INIT_MODE = 0,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic          clk_in12mhz,
  input  logic          reset,
  input  logic [MW-1:0] mode_sel,
  input  logic          switch_req,
  output logic          busy,
  output logic [MW-1:0] cur_mode,
  output logic          locked,
  output logic          error,
  output logic          mmcm_rst,
  input  logic          mmcm_locked,
  output logic [6:0]    drp_daddr,
  output logic          drp_den,
  output logic          drp_dwe,
  output logic [15:0]   drp_di,
  input  logic [15:0]   drp_do,
  input  logic          drp_drdy
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TMAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1) + 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_ASSERT,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
`ifdef DOT4X_RECONFIG_VERIFY_EN
    ST_VFY,
    ST_VFY_WAIT,
`endif
    ST_NEXT,
    ST_RELEASE,
    ST_LOCK_WAIT,
    ST_ERROR
  } state_t;

  state_t          r_state;
  logic [MW-1:0]   r_curMode;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_tmo;
  logic            r_busy;
  logic            r_locked;
  logic            r_error;
  logic            r_mmcmRst;
  logic            r_den;
  logic            r_dwe;
  logic [6:0]      r_daddr;
  logic [15:0]     r_di;

  // Entries past the last register read as zero so the look-ahead address never indexes off the table.
  function automatic logic [38:0] tblEntry(input logic [MW-1:0] m, input logic [IW:0] i);
    logic [38:0] e;
    e = '0;
    if (int'(i) < NUM_REGS)
      e = DRP_TABLE[(int'(m) * NUM_REGS + int'(i)) * 39 +: 39];
    return e;
  endfunction

  function automatic logic [6:0] tblAddr(input logic [MW-1:0] m, input logic [IW:0] i);
    logic [38:0] e;
    e = tblEntry(m, i);
    return e[38:32];
  endfunction

  logic [38:0]   w_entry;
  logic [6:0]    w_addr;
  logic [6:0]    w_nextAddr;
  logic [15:0]   w_mask;
  logic [15:0]   w_data;
  logic [15:0]   w_merged;
  logic [MW:0]   w_selExt;
  logic [MW-1:0] w_reqMode;
  logic          w_lastReg;

  assign w_entry    = tblEntry(r_curMode, {1'b0, r_idx});
  assign w_addr     = w_entry[38:32];
  assign w_mask     = w_entry[31:16];
  assign w_data     = w_entry[15:0];
  assign w_nextAddr = tblAddr(r_curMode, {1'b0, r_idx} + (IW+1)'(1));
  assign w_merged   = (drp_do & w_mask) | (w_data & ~w_mask);
  assign w_selExt   = {1'b0, mode_sel};
  assign w_reqMode  = (w_selExt > (MW+1)'(NUM_MODES - 1)) ? MW'(NUM_MODES - 1) : mode_sel;
  assign w_lastReg  = (r_idx == IW'(NUM_REGS - 1));

  // r_tmo free-runs and is cleared on every state change, so each wait state sees its own dwell time.
  always_ff @(posedge clk_in12mhz or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RST_ASSERT;
      r_curMode <= MW'(INIT_MODE);
      r_idx     <= '0;
      r_tmo     <= '0;
      r_busy    <= 1'b1;
      r_locked  <= 1'b0;
      r_error   <= 1'b0;
      r_mmcmRst <= 1'b1;
      r_den     <= 1'b0;
      r_dwe     <= 1'b0;
      r_daddr   <= '0;
      r_di      <= '0;
    end else begin
      r_tmo    <= r_tmo + TW'(1);
      r_locked <= (r_state == ST_IDLE) && mmcm_locked;
      case (r_state)
        ST_IDLE, ST_ERROR: begin
          if (switch_req) begin
            r_curMode <= w_reqMode;
            r_idx     <= '0;
            r_error   <= 1'b0;
            r_busy    <= 1'b1;
            r_mmcmRst <= 1'b1;
            r_tmo     <= '0;
            r_state   <= ST_RST_ASSERT;
          end
        end
        ST_RST_ASSERT: begin
          r_den   <= 1'b1;
          r_dwe   <= 1'b0;
          r_daddr <= w_addr;
          r_tmo   <= '0;
          r_state <= ST_RD;
        end
        ST_RD: begin
          r_den   <= 1'b0;
          r_tmo   <= '0;
          r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (drp_drdy) begin
            r_den   <= 1'b1;
            r_dwe   <= 1'b1;
            r_di    <= w_merged;
            r_tmo   <= '0;
            r_state <= ST_WR;
          end else if (r_tmo >= TW'(DRDY_TIMEOUT)) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_tmo   <= '0;
            r_state <= ST_ERROR;
          end
        end
        ST_WR: begin
          r_den   <= 1'b0;
          r_dwe   <= 1'b0;
          r_tmo   <= '0;
          r_state <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (drp_drdy) begin
            r_tmo <= '0;
`ifdef DOT4X_RECONFIG_VERIFY_EN
            r_den   <= 1'b1;
            r_state <= ST_VFY;
`else
            r_state <= ST_NEXT;
`endif
          end else if (r_tmo >= TW'(DRDY_TIMEOUT)) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_tmo   <= '0;
            r_state <= ST_ERROR;
          end
        end
`ifdef DOT4X_RECONFIG_VERIFY_EN
        ST_VFY: begin
          r_den   <= 1'b0;
          r_tmo   <= '0;
          r_state <= ST_VFY_WAIT;
        end
        // r_di still holds the value just written, so it doubles as the readback reference.
        ST_VFY_WAIT: begin
          if (drp_drdy && (drp_do == r_di)) begin
            r_tmo   <= '0;
            r_state <= ST_NEXT;
          end else if (drp_drdy || (r_tmo >= TW'(DRDY_TIMEOUT))) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_tmo   <= '0;
            r_state <= ST_ERROR;
          end
        end
`endif
        ST_NEXT: begin
          r_tmo <= '0;
          if (w_lastReg) begin
            r_mmcmRst <= 1'b0;
            r_state   <= ST_RELEASE;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_den   <= 1'b1;
            r_dwe   <= 1'b0;
            r_daddr <= w_nextAddr;
            r_state <= ST_RD;
          end
        end
        ST_RELEASE: begin
          r_tmo   <= '0;
          r_state <= ST_LOCK_WAIT;
        end
        ST_LOCK_WAIT: begin
          if (mmcm_locked) begin
            r_busy  <= 1'b0;
            r_tmo   <= '0;
            r_state <= ST_IDLE;
          end else if (r_tmo >= TW'(LOCK_TIMEOUT)) begin
            r_error   <= 1'b1;
            r_busy    <= 1'b0;
            r_mmcmRst <= 1'b1;
            r_tmo     <= '0;
            r_state   <= ST_ERROR;
          end
        end
        default: begin
          r_busy    <= 1'b1;
          r_mmcmRst <= 1'b1;
          r_den     <= 1'b0;
          r_dwe     <= 1'b0;
          r_idx     <= '0;
          r_tmo     <= '0;
          r_state   <= ST_RST_ASSERT;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign cur_mode  = r_curMode;
  assign locked    = r_locked;
  assign error     = r_error;
  assign mmcm_rst  = r_mmcmRst;
  assign drp_daddr = r_daddr;
  assign drp_den   = r_den;
  assign drp_dwe   = r_dwe;
  assign drp_di    = r_di;

endmodule
